// File: rtl/sram_wb_bridge.sv
// Wishbone classic slave bridge onto read/write port 0 of a 32x256 OpenRAM macro.
// Zero-fills the array after reset. Each accepted request becomes one macro
// command, with a registered ack two edges after the request is sampled.
module sram_wb_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic [31:0]             i_wb_adr,
  input  logic [DATA_WIDTH-1:0]   i_wb_dat,
  input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
  input  logic                    i_wb_we,
  input  logic                    i_wb_cyc,
  input  logic                    i_wb_stb,
  output logic [DATA_WIDTH-1:0]   o_wb_rdt,
  output logic                    o_wb_ack,
  output logic                    o_init_done,
  output logic                    o_sram_csb0,
  output logic                    o_sram_web0,
  output logic [DATA_WIDTH/8-1:0] o_sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   o_sram_addr0,
  output logic [DATA_WIDTH-1:0]   o_sram_din0,
  input  logic [DATA_WIDTH-1:0]   i_sram_dout0
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_ACKD
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_cmd;
  logic                  req;

  // Only the word-address bits reach the macro; the rest of the byte address is ignored.
  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:ADDR_WIDTH+2], i_wb_adr[1:0]};

  // A request is any cycle with both cyc and stb asserted.
  always_comb begin
    req = i_wb_cyc & i_wb_stb;
  end

  // Sequencer: zero-fill, then one IDLE->ISSUE->CAPT->ACKD pass per access.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state         <= INIT_EN ? S_INIT : S_IDLE;
      init_cnt      <= '0;
      rd_cmd        <= 1'b0;
      o_sram_csb0   <= 1'b1;
      o_sram_web0   <= 1'b1;
      o_sram_wmask0 <= '0;
      o_sram_addr0  <= '0;
      o_sram_din0   <= '0;
      o_wb_ack      <= 1'b0;
      o_wb_rdt      <= '0;
      o_init_done   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          o_sram_csb0   <= 1'b0;
          o_sram_web0   <= 1'b0;
          o_sram_wmask0 <= '1;
          o_sram_din0   <= '0;
          o_sram_addr0  <= init_cnt;
          init_cnt      <= init_cnt + ADDR_WIDTH'(1);
          // The last fill write is still on the pins; IDLE releases csb0 next edge.
          if (init_cnt == '1) begin
            o_init_done <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_IDLE: begin
          o_init_done <= 1'b1;
          if (req) begin
            o_sram_csb0   <= 1'b0;
            o_sram_web0   <= ~i_wb_we;
            o_sram_addr0  <= i_wb_adr[ADDR_WIDTH+1:2];
            o_sram_din0   <= i_wb_dat;
            o_sram_wmask0 <= i_wb_we ? i_wb_sel : '0;
            rd_cmd        <= ~i_wb_we;
            state         <= S_ISSUE;
          end else begin
            o_sram_csb0 <= 1'b1;
            o_sram_web0 <= 1'b1;
          end
        end
        S_ISSUE: begin
          o_sram_csb0 <= 1'b1;
          o_sram_web0 <= 1'b1;
          state       <= S_CAPT;
        end
        S_CAPT: begin
          if (rd_cmd) begin
            o_wb_rdt <= i_sram_dout0;
          end
          o_wb_ack <= 1'b1;
          state    <= S_ACKD;
        end
        S_ACKD: begin
          o_wb_ack <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Directed bench for sram_wb_bridge with a behavioural model of the OpenRAM port 0.
module tb_sram_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we  = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        init_done;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;

  int errors = 0;
  int checks = 0;

  // Pins seen on the edge that sampled the most recent request.
  logic        cap_csb;
  logic        cap_web;
  logic [3:0]  cap_mask;
  logic [7:0]  cap_addr;
  logic [31:0] cap_din;

  sram_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .INIT_EN(1'b1)) dut (
    .clk0         (clk),
    .rst0         (rst),
    .i_wb_adr     (wb_adr),
    .i_wb_dat     (wb_dat),
    .i_wb_sel     (wb_sel),
    .i_wb_we      (wb_we),
    .i_wb_cyc     (wb_cyc),
    .i_wb_stb     (wb_stb),
    .o_wb_rdt     (wb_rdt),
    .o_wb_ack     (wb_ack),
    .o_init_done  (init_done),
    .o_sram_csb0  (csb0),
    .o_sram_web0  (web0),
    .o_sram_wmask0(wmask0),
    .o_sram_addr0 (addr0),
    .o_sram_din0  (din0),
    .i_sram_dout0 (dout0)
  );

  always #5 clk = ~clk;

  // Macro model: command sampled at posedge, write lands / read data appears at negedge,
  // dout goes X on every posedge.
  logic [31:0] mem [0:255];
  logic        p_pend = 1'b0;
  logic        p_we;
  logic [3:0]  p_mask;
  logic [7:0]  p_addr;
  logic [31:0] p_din;

  always @(posedge clk) begin
    dout0  <= 'x;
    p_pend <= ~csb0;
    p_we   <= ~web0;
    p_mask <= wmask0;
    p_addr <= addr0;
    p_din  <= din0;
  end

  always @(negedge clk) begin
    if (p_pend) begin
      if (p_we) begin
        for (int b = 0; b < 4; b++) begin
          if (p_mask[b]) mem[p_addr][b*8 +: 8] <= p_din[b*8 +: 8];
        end
      end else begin
        dout0 <= mem[p_addr];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone access; lat is the number of edges (first = sampling edge) until ack is seen.
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdt, output int lat);
    wb_we  = we;
    wb_adr = adr;
    wb_dat = dat;
    wb_sel = sel;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    lat    = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 1) begin
        cap_csb  = csb0;
        cap_web  = web0;
        cap_mask = wmask0;
        cap_addr = addr0;
        cap_din  = din0;
      end
      if (wb_ack) begin
        lat = e;
        break;
      end
    end
    rdt    = wb_rdt;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    tick();
  endtask

  // Follows a zero-fill from the edge after reset release.
  task automatic run_init_check();
    int wcount = 0;
    int done_e = 0;
    for (int e = 1; e <= 400; e++) begin
      tick();
      checks++;
      if (wb_ack !== 1'b0) begin
        errors++;
        $display("FAIL init_no_ack edge=%0d ack=%b expected 0", e, wb_ack);
      end
      if (csb0 === 1'b0) begin
        checks++;
        if (addr0 !== wcount[7:0] || din0 !== 32'h0 || wmask0 !== 4'hF || web0 !== 1'b0) begin
          errors++;
          $display("FAIL init_write edge=%0d addr=%0d din=%h mask=%h web=%b expected addr=%0d din=0 mask=F web=0",
                   e, addr0, din0, wmask0, web0, wcount);
        end
        wcount++;
      end
      if (init_done === 1'b1) begin
        done_e = e;
        break;
      end
    end
    checks++;
    if (done_e != 256) begin
      errors++;
      $display("FAIL init_done_edge got=%0d expected 256", done_e);
    end
    checks++;
    if (wcount != 256) begin
      errors++;
      $display("FAIL init_write_count got=%0d expected 256", wcount);
    end
    tick();
    checks++;
    if (csb0 !== 1'b1 || web0 !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_release csb=%b web=%b done=%b expected 1 1 1", csb0, web0, init_done);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    checks++;
    if (csb0 !== 1'b1 || web0 !== 1'b1 || wmask0 !== 4'h0 || addr0 !== 8'h0 || din0 !== 32'h0) begin
      errors++;
      $display("FAIL %s_pins csb=%b web=%b mask=%h addr=%h din=%h expected 1 1 0 00 00000000",
               tag, csb0, web0, wmask0, addr0, din0);
    end
    checks++;
    if (wb_ack !== 1'b0 || wb_rdt !== 32'h0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_bus ack=%b rdt=%h done=%b expected 0 00000000 0", tag, wb_ack, wb_rdt, init_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_pins("reset");
    rst = 1'b0;
    run_init_check();
  endtask

  task automatic test_init_read();
    logic [31:0] r;
    int lat;
    wb_access(1'b0, 32'h3FC, 32'h0, 4'hF, r, lat);
    checks++;
    if (lat != 3 || r !== 32'h0) begin
      errors++;
      $display("FAIL read_3fc lat=%0d rdt=%h expected lat=3 rdt=00000000", lat, r);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] r;
    int lat;
    wb_access(1'b1, 32'h010, 32'hDEADBEEF, 4'hF, r, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL write_lat got=%0d expected 3", lat);
    end
    checks++;
    if (cap_csb !== 1'b0 || cap_web !== 1'b0 || cap_mask !== 4'hF || cap_addr !== 8'h04 || cap_din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_pins csb=%b web=%b mask=%h addr=%h din=%h expected 0 0 F 04 deadbeef",
               cap_csb, cap_web, cap_mask, cap_addr, cap_din);
    end
    wb_access(1'b0, 32'h010, 32'h0, 4'hF, r, lat);
    checks++;
    if (lat != 3 || r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_010 lat=%0d rdt=%h expected lat=3 rdt=deadbeef", lat, r);
    end
    checks++;
    if (cap_web !== 1'b1 || cap_mask !== 4'h0 || cap_addr !== 8'h04) begin
      errors++;
      $display("FAIL read_pins web=%b mask=%h addr=%h expected 1 0 04", cap_web, cap_mask, cap_addr);
    end
    // Bit 10 lies above the word address and must be ignored.
    wb_access(1'b0, 32'h410, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_alias rdt=%h expected deadbeef", r);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r;
    int lat;
    wb_access(1'b1, 32'h020, 32'h11223344, 4'hF, r, lat);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_keeps_rdt rdt=%h expected deadbeef", r);
    end
    wb_access(1'b1, 32'h020, 32'hAABBCCDD, 4'b0101, r, lat);
    checks++;
    if (cap_mask !== 4'b0101) begin
      errors++;
      $display("FAIL lane_mask got=%h expected 5", cap_mask);
    end
    wb_access(1'b0, 32'h020, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_lanes rdt=%h expected 11bb33dd", r);
    end
    wb_access(1'b1, 32'h020, 32'h55555555, 4'h0, r, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL sel0_ack lat=%0d expected 3", lat);
    end
    wb_access(1'b0, 32'h020, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL sel0_unchanged rdt=%h expected 11bb33dd", r);
    end
  endtask

  task automatic test_back_to_back();
    int n_ack = 0;
    int first_e = 0;
    int second_e = 0;
    wb_we  = 1'b0;
    wb_adr = 32'h010;
    wb_sel = 4'hF;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (wb_ack === 1'b1) begin
        n_ack++;
        if (n_ack == 1) first_e = e;
        if (n_ack == 2) second_e = e;
        checks++;
        if (wb_rdt !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL b2b_rdt edge=%0d rdt=%h expected deadbeef", e, wb_rdt);
        end
      end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    checks++;
    if (n_ack != 2 || first_e != 3 || second_e != 7) begin
      errors++;
      $display("FAIL b2b_acks count=%0d at %0d,%0d expected 2 at 3,7", n_ack, first_e, second_e);
    end
    tick();
    tick();
    checks++;
    if (wb_ack !== 1'b0 || csb0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_quiet ack=%b csb=%b expected 0 1", wb_ack, csb0);
    end
  endtask

  task automatic test_reset_mid_op();
    wb_we  = 1'b0;
    wb_adr = 32'h010;
    wb_sel = 4'hF;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    tick();
    checks++;
    if (csb0 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cmd csb=%b expected 0", csb0);
    end
    rst = 1'b1;
    tick();
    check_reset_pins("midrst");
    rst    = 1'b0;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    run_init_check();
  endtask

  task automatic test_held_during_init();
    logic [31:0] r;
    int lat;
    int ack_e = 0;
    rst    = 1'b1;
    wb_we  = 1'b1;
    wb_adr = 32'h044;
    wb_dat = 32'h600DF00D;
    wb_sel = 4'hF;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 400; e++) begin
      tick();
      if (wb_ack === 1'b1) begin
        ack_e = e;
        break;
      end
    end
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    checks++;
    if (ack_e != 259) begin
      errors++;
      $display("FAIL held_ack_edge got=%0d expected 259", ack_e);
    end
    tick();
    wb_access(1'b0, 32'h044, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'h600DF00D) begin
      errors++;
      $display("FAIL held_readback rdt=%h expected 600df00d", r);
    end
    wb_access(1'b0, 32'h048, 32'h0, 4'hF, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL held_neighbour rdt=%h expected 00000000", r);
    end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_reset_mid_op();
    test_held_during_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
